// File: rtl/fp16_pkg.sv
// Shared FP16 (binary16) field widths, constants, classify helpers and the
// accumulator state encoding; also used by the multiplier.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;

    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
    localparam logic [15:0] FP16_NEG_INF  = 16'hFC00;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_OUT
    } acc_state_t;

    function automatic fp16_t unpack(input logic [15:0] x);
        return fp16_t'(x);
    endfunction

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != '0);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] == '0);
    endfunction

    function automatic logic is_zero_or_sub(input logic [15:0] x);
        return x[14:10] == '0;
    endfunction

    // Significand with hidden bit plus three guard bits; subnormals flush to 0.
    function automatic logic [13:0] sig14(input logic [15:0] x);
        return is_zero_or_sub(x) ? 14'd0 : {1'b1, x[9:0], 3'b000};
    endfunction

    function automatic logic [13:0] align_shift(input logic [13:0] sig, input logic [4:0] d);
        return (d >= 5'd14) ? 14'd0 : (sig >> d);
    endfunction

endpackage

// File: rtl/fp16_normalize.sv
// Combinational normaliser: leading-one detect on a 15-bit magnitude, left
// shift, exponent adjust and overflow/underflow/zero flags.
module fp16_normalize
    import fp16_pkg::*;
(
    input  logic [14:0] sum,
    input  logic [4:0]  exp_in,
    output logic [4:0]  exp_out,
    output logic [9:0]  man_out,
    output logic        zero,
    output logic        ovf,
    output logic        unf
);

    logic [3:0]        lead;
    logic [3:0]        sh;
    logic [14:0]       norm;
    logic signed [6:0] e_s;

    always_comb begin
        lead = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (sum[i]) lead = 4'(i);
        end
        sh      = 4'd14 - lead;
        norm    = sum << sh;
        // bit 13 of the significand carries weight 2^0, so the leading one at
        // position 'lead' moves the exponent by lead-13
        e_s     = $signed({2'b00, exp_in}) + $signed({3'b000, lead}) - 7'sd13;
        zero    = (sum == '0);
        ovf     = !zero && (e_s > 7'sd30);
        unf     = !zero && (e_s < 7'sd1);
        exp_out = e_s[4:0];
        man_out = 10'(norm >> 4);
    end

endmodule

// File: rtl/fp16_accumulator.sv
// Streaming FP16 accumulator: sums one vector of terms (closed by in_last),
// one addition per accepted term in a fixed 4-cycle ALIGN/ADD/NORM sequence.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a term; capture term/last, bump counter
// ALIGN | unpack acc and term, shift smaller-exponent significand, flag specials
// ADD   | signed-magnitude add/subtract of the aligned significands
// NORM  | normalise, truncate, repack, write accumulator
// OUT   | present sum/count, hold until out_ready, then clear
module fp16_accumulator
    import fp16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    acc_state_t        state;
    logic [15:0]       acc, term;
    logic              last_f;
    logic [CNT_W-1:0]  cnt;

    logic              special;
    logic [15:0]       special_val;
    logic              sa, sb;
    logic [4:0]        e_big;
    logic [13:0]       ma, mb;
    logic [14:0]       sum;
    logic              s_sign;

    fp16_t             fa, fb;
    logic [4:0]        ea, eb;
    logic [13:0]       sig_a, sig_b;
    logic              nan_res;
    logic              al_special;
    logic [15:0]       al_special_val;
    logic [4:0]        al_big;
    logic [13:0]       al_a, al_b;

    logic [14:0]       add_sum;
    logic              add_sign;

    logic [4:0]        n_exp;
    logic [9:0]        n_man;
    logic              n_zero, n_ovf, n_unf;
    logic [15:0]       norm_res;

    always_comb begin
        fa    = unpack(acc);
        fb    = unpack(term);
        ea    = is_zero_or_sub(acc)  ? 5'd0 : fa.exp;
        eb    = is_zero_or_sub(term) ? 5'd0 : fb.exp;
        sig_a = sig14(acc);
        sig_b = sig14(term);
        if (ea >= eb) begin
            al_big = ea;
            al_a   = sig_a;
            al_b   = align_shift(sig_b, ea - eb);
        end else begin
            al_big = eb;
            al_a   = align_shift(sig_a, eb - ea);
            al_b   = sig_b;
        end
        nan_res        = is_nan(acc) || is_nan(term) ||
                         (is_inf(acc) && is_inf(term) && (fa.sign != fb.sign));
        al_special     = nan_res || is_inf(acc) || is_inf(term);
        al_special_val = nan_res ? FP16_QNAN : (is_inf(acc) ? acc : term);
    end

    always_comb begin
        if (sa == sb) begin
            add_sum  = {1'b0, ma} + {1'b0, mb};
            add_sign = sa;
        end else if (ma >= mb) begin
            add_sum  = {1'b0, ma - mb};
            add_sign = sa;
        end else begin
            add_sum  = {1'b0, mb - ma};
            add_sign = sb;
        end
    end

    fp16_normalize u_norm (
        .sum     (sum),
        .exp_in  (e_big),
        .exp_out (n_exp),
        .man_out (n_man),
        .zero    (n_zero),
        .ovf     (n_ovf),
        .unf     (n_unf)
    );

    always_comb begin
        if (special)
            norm_res = special_val;
        else if (n_zero || n_unf)
            norm_res = FP16_POS_ZERO;
        else if (n_ovf)
            norm_res = s_sign ? FP16_NEG_INF : FP16_POS_INF;
        else
            norm_res = {s_sign, n_exp, n_man};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            acc         <= FP16_POS_ZERO;
            term        <= '0;
            last_f      <= 1'b0;
            cnt         <= '0;
            special     <= 1'b0;
            special_val <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            e_big       <= '0;
            ma          <= '0;
            mb          <= '0;
            sum         <= '0;
            s_sign      <= 1'b0;
            in_ready    <= 1'b1;
            out_data    <= '0;
            out_count   <= '0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        term     <= in_data;
                        last_f   <= in_last;
                        if (cnt != '1) cnt <= cnt + 1'b1;
                        in_ready <= 1'b0;
                        state    <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    sa          <= fa.sign;
                    sb          <= fb.sign;
                    e_big       <= al_big;
                    ma          <= al_a;
                    mb          <= al_b;
                    special     <= al_special;
                    special_val <= al_special_val;
                    state       <= ST_ADD;
                end
                ST_ADD: begin
                    sum    <= add_sum;
                    s_sign <= add_sign;
                    state  <= ST_NORM;
                end
                ST_NORM: begin
                    acc <= norm_res;
                    if (last_f) begin
                        state <= ST_OUT;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    // first OUT cycle loads the result; later cycles wait for the consumer
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= acc;
                        out_count <= cnt;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= FP16_POS_ZERO;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
